// File: rtl/nios_processor_pio_edge.sv
`default_nettype none
// ============================================================================
// Module  : nios_processor_pio_edge
// Brief   : Avalon-MM bidirectional PIO slave with synchronised, optionally
//           debounced inputs, per-bit edge capture and maskable level irq.
// Revision: 1.0 - initial release
// ============================================================================
module nios_processor_pio_edge #(
  parameter int               WIDTH     = 8,
  parameter int               DEBOUNCE  = 0,
  parameter int               EDGE_TYPE = 0,
  parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] port_dir,
  output logic             irq
);

  localparam logic [1:0] c_ADDR_DATA = 2'd0;
  localparam logic [1:0] c_ADDR_DIR  = 2'd1;
  localparam logic [1:0] c_ADDR_MASK = 2'd2;
  localparam logic [1:0] c_ADDR_CAP  = 2'd3;

  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_fprev;
  logic [31:0]      r_rdata;
  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_evt;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_rmux;
  logic [WIDTH-1:0] w_wdata;
  logic             w_wr;

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];

  if (WIDTH < 32) begin : g_unused_wd
    logic w_unused_wd;
    assign w_unused_wd = &{1'b0, writedata[31:WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
    end
  end

  if (DEBOUNCE == 0) begin : g_nodeb
    assign w_f = r_s2;
  end else begin : g_deb
    localparam logic [15:0] c_LAST = 16'(DEBOUNCE - 1);
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic [15:0] r_cnt;
      logic        r_f;
      // Filtered bit follows s2 only after it has differed for DEBOUNCE cycles
      always_ff @(posedge clk) begin
        if (reset) begin
          r_cnt <= '0;
          r_f   <= 1'b0;
        end else if (r_s2[i] == r_f) begin
          r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
          r_f   <= r_s2[i];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
      assign w_f[i] = r_f;
    end
  end

  if (EDGE_TYPE == 1) begin : g_fall
    assign w_evt = ~w_f & r_fprev;
  end else if (EDGE_TYPE == 2) begin : g_any
    assign w_evt = w_f ^ r_fprev;
  end else begin : g_rise
    assign w_evt = w_f & ~r_fprev;
  end

  assign w_clr = (w_wr && (address == c_ADDR_CAP)) ? w_wdata : '0;

  always_comb begin
    w_rmux = '0;
    case (address)
      c_ADDR_DATA: w_rmux = (r_out & r_dir) | (w_f & ~r_dir);
      c_ADDR_DIR:  w_rmux = r_dir;
      c_ADDR_MASK: w_rmux = r_mask;
      default:     w_rmux = r_cap;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out   <= OUT_RESET;
      r_dir   <= '0;
      r_mask  <= '0;
      r_cap   <= '0;
      r_fprev <= '0;
      r_rdata <= '0;
    end else begin
      r_fprev <= w_f;
      r_rdata <= 32'(w_rmux);
      // A new event outranks a simultaneous software clear of the same bit
      r_cap   <= (r_cap & ~w_clr) | w_evt;
      if (w_wr) begin
        case (address)
          c_ADDR_DATA: r_out  <= w_wdata;
          c_ADDR_DIR:  r_dir  <= w_wdata;
          c_ADDR_MASK: r_mask <= w_wdata;
          default:     ;
        endcase
      end
    end
  end

  assign readdata = r_rdata;
  assign out_port = r_out;
  assign port_dir = r_dir;
  assign irq      = |(r_cap & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_nios_processor_pio_edge.sv
`default_nettype none
// ============================================================================
// Module  : tb_nios_processor_pio_edge
// Brief   : Scoreboard bench for four PIO configurations on a shared bus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_nios_processor_pio_edge;

  localparam int c_SIG_RD  = 0;
  localparam int c_SIG_IRQ = 1;
  localparam int c_SIG_OUT = 2;
  localparam int c_SIG_DIR = 3;

  typedef struct {
    int          dut;
    int          sig;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  tb_in [4];
  logic [31:0] rdd   [4];
  logic [7:0]  outv  [4];
  logic [7:0]  dirv  [4];
  logic        irqv  [4];

  item_t q[$];
  int    req_cnt = 0;
  int    r_pend  = 0;
  int    n_chk   = 0;
  int    n_fail  = 0;

  always #5 clk = ~clk;

  nios_processor_pio_edge #(.WIDTH(8), .DEBOUNCE(0), .EDGE_TYPE(0), .OUT_RESET(8'hA5)) u_dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rdd[0]), .in_port(tb_in[0]), .out_port(outv[0]),
    .port_dir(dirv[0]), .irq(irqv[0]));

  nios_processor_pio_edge #(.WIDTH(8), .DEBOUNCE(4), .EDGE_TYPE(0), .OUT_RESET(8'h00)) u_dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rdd[1]), .in_port(tb_in[1]), .out_port(outv[1]),
    .port_dir(dirv[1]), .irq(irqv[1]));

  nios_processor_pio_edge #(.WIDTH(8), .DEBOUNCE(0), .EDGE_TYPE(2), .OUT_RESET(8'h00)) u_dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rdd[2]), .in_port(tb_in[2]), .out_port(outv[2]),
    .port_dir(dirv[2]), .irq(irqv[2]));

  nios_processor_pio_edge #(.WIDTH(8), .DEBOUNCE(0), .EDGE_TYPE(1), .OUT_RESET(8'h00)) u_dut3 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rdd[3]), .in_port(tb_in[3]), .out_port(outv[3]),
    .port_dir(dirv[3]), .irq(irqv[3]));

  function automatic logic [31:0] actual(int d, int s);
    case (s)
      c_SIG_RD:  return rdd[d];
      c_SIG_IRQ: return {31'b0, irqv[d]};
      c_SIG_OUT: return {24'b0, outv[d]};
      default:   return {24'b0, dirv[d]};
    endcase
  endfunction

  // Items pushed during a cycle are judged after the following rising edge
  always @(posedge clk) r_pend <= req_cnt;

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < r_pend; i++) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow: nothing queued for a due check");
      end else begin
        item_t it;
        logic [31:0] act;
        it  = q.pop_front();
        act = actual(it.dut, it.sig);
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: dut%0d got %h, expected %h", it.name, it.dut, act, it.exp);
        end
      end
    end
  end

  task automatic chk(input int d, input int s, input logic [31:0] e, input string n);
    q.push_back('{d, s, e, n});
    req_cnt++;
  endtask

  task automatic step();
    @(negedge clk);
    req_cnt = 0;
  endtask

  task automatic rd(input int d, input logic [1:0] a, input logic [31:0] e, input string n);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    chk(d, c_SIG_RD, e, n);
    step();
    chipselect = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] dat);
    address    = a;
    writedata  = dat;
    chipselect = 1'b1;
    write_n    = 1'b0;
    step();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    for (int i = 0; i < 4; i++) tb_in[i] = 8'h00;

    // Reset state
    step(); step();
    chk(0, c_SIG_OUT, 32'hA5, "rst_out");
    chk(0, c_SIG_DIR, 32'h00, "rst_dir");
    chk(0, c_SIG_RD,  32'h00, "rst_rdata");
    chk(0, c_SIG_IRQ, 32'h0,  "rst_irq");
    step();
    reset = 1'b0;
    rd(0, 2'd3, 32'h00, "rst_cap");

    // Rising capture and irq latency
    wr(2'd2, 32'h01);
    tb_in[0][0] = 1'b1;
    step();
    chk(0, c_SIG_IRQ, 32'h0, "irq_k1");
    step();
    chk(0, c_SIG_IRQ, 32'h1, "irq_k2");
    step();
    rd(0, 2'd3, 32'h01, "cap_rise");
    address = 2'd3; writedata = 32'h01; chipselect = 1'b1; write_n = 1'b0;
    chk(0, c_SIG_IRQ, 32'h0, "irq_clr");
    step();
    chipselect = 1'b0; write_n = 1'b1;
    tb_in[0][0] = 1'b0;
    repeat (4) step();
    rd(0, 2'd3, 32'h00, "no_fall_cap");

    // Debounce: 3-cycle glitch rejected
    tb_in[1][3] = 1'b1;
    repeat (3) step();
    tb_in[1][3] = 1'b0;
    repeat (6) step();
    rd(1, 2'd0, 32'h00, "glitch_data");
    rd(1, 2'd3, 32'h00, "glitch_cap");

    // Debounce: held level accepted after 4 stable cycles
    tb_in[1][3] = 1'b1;
    repeat (5) step();
    rd(1, 2'd0, 32'h00, "deb_before");
    rd(1, 2'd3, 32'h00, "deb_cap_before");
    rd(1, 2'd3, 32'h08, "deb_cap");
    rd(1, 2'd0, 32'h08, "deb_data");

    // Set beats clear on the same bit in the same cycle
    tb_in[0][2] = 1'b1;
    step(); step();
    address = 2'd3; writedata = 32'h04; chipselect = 1'b1; write_n = 1'b0;
    step();
    chipselect = 1'b0; write_n = 1'b1;
    rd(0, 2'd3, 32'h04, "set_wins");
    wr(2'd3, 32'h04);
    rd(0, 2'd3, 32'h00, "cap_w1c");

    // Direction-dependent data readback
    wr(2'd1, 32'hF0);
    wr(2'd0, 32'h3C);
    tb_in[0] = 8'h0F;
    repeat (3) step();
    rd(0, 2'd0, 32'h3F, "dir_data");
    chk(0, c_SIG_OUT, 32'h3C, "out_port");
    chk(0, c_SIG_DIR, 32'hF0, "port_dir");
    step();
    rd(0, 2'd1, 32'hF0, "dir_read");
    rd(0, 2'd2, 32'h01, "mask_read");

    // Any-edge mode
    tb_in[2][7] = 1'b1;
    repeat (3) step();
    rd(2, 2'd3, 32'h80, "any_rise");
    wr(2'd3, 32'h80);
    rd(2, 2'd3, 32'h00, "any_clr");
    tb_in[2][7] = 1'b0;
    repeat (3) step();
    rd(2, 2'd3, 32'h80, "any_fall");

    // Falling-edge mode
    tb_in[3][7] = 1'b1;
    repeat (4) step();
    rd(3, 2'd3, 32'h00, "fall_no_rise");
    tb_in[3][7] = 1'b0;
    repeat (3) step();
    rd(3, 2'd3, 32'h80, "fall_cap");

    // Reset while irq is asserted
    chk(0, c_SIG_IRQ, 32'h1, "irq_pre_rst");
    step();
    reset = 1'b1;
    chk(0, c_SIG_IRQ, 32'h0,  "irq_rst");
    chk(0, c_SIG_OUT, 32'hA5, "out_rst2");
    step();
    reset = 1'b0;

    repeat (3) step();
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d checks left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nios_processor_pio_edge.md
# nios_processor_pio_edge

Parametrised Avalon-MM parallel I/O slave for the Nios II subsystem, generalising the single-bit input-only port to WIDTH bidirectional bits. Each bit has a two-flop input synchroniser, an optional debounce filter, a direction bit and a configurable edge-capture register. The block drives a maskable level interrupt. It connects to buttons, switches and LEDs on the board, with one instance per port group.

## Interface
Parameters:
- WIDTH, 8: number of I/O bits, 1..32.
- DEBOUNCE, 0: stable-cycle count required before the filtered input updates. 0 bypasses the filter. Legal range 0..65535.
- EDGE_TYPE, 0: capture condition. 0 rising, 1 falling, 2 any edge.
- OUT_RESET, 0: reset value of the output data register, WIDTH bits.

Ports:
- clk  in  1  system clock, single domain.
- reset  in  1  synchronous, active-high reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data. Bits above WIDTH are ignored.
- readdata  out  32  registered read data. Bits above WIDTH read 0.
- in_port  in  WIDTH  asynchronous external inputs.
- out_port  out  WIDTH  output data register.
- port_dir  out  WIDTH  direction register. 1 = output, for external tristate control.
- irq  out  1  level interrupt.

## Operation
Register map:
- Address 0, data:
  - Write loads out_port.
  - Read returns, per bit, out_port[i] if port_dir[i] is 1, else filtered input f[i].
- Address 1, direction: read/write. Reset value 0, so all bits are inputs.
- Address 2, irq mask: read/write. Reset value 0.
- Address 3, edge capture:
  - Read returns the capture bits.
  - Write-1-to-clear per bit. Writing 0 has no effect.

Input path, per bit:
- Synchroniser: s1 <= in_port, s2 <= s1.
- Filter when DEBOUNCE = 0: f = s2 (wire).
- Filter when DEBOUNCE > 0: f is a register with a 16-bit counter cnt.
  - If s2 == f, cnt <= 0.
  - Otherwise cnt increments.
  - When cnt == DEBOUNCE-1 and s2 != f, f <= s2 and cnt <= 0.
  - Any glitch shorter than DEBOUNCE cycles leaves f unchanged.
- Edge detect: f_prev <= f. The event condition depends on EDGE_TYPE:
  - Rising: f & ~f_prev.
  - Falling: ~f & f_prev.
  - Any: f ^ f_prev.
- Capture: cap[i] <= 1 on an event. A bit holds until cleared by software or by reset.
- Set and clear of the same bit in the same cycle: set wins.
- Edges are captured regardless of direction and mask.
- irq = |(cap & mask), a combinational OR of registers (no glitch source).
- A write to address 3 with chipselect low is ignored. The same holds for every write.

Reset (synchronous, active-high):
- readdata = 0, irq = 0, out_port = OUT_RESET, port_dir = 0, mask = 0, cap = 0.
- s1, s2, f, f_prev and cnt are all 0.
- Because f_prev resets to 0, an input held high through reset produces a rising edge after release. This is intended and documented for software.

## Timing
- Writes take effect at the clock edge where chipselect = 1 and write_n = 0. The new value is visible on out_port, port_dir or mask after that edge.
- readdata is registered on every clock from the address mux, independent of chipselect: readdata <= {0, mux(address)}. Read latency is 1 cycle (Avalon fixed read latency 1).
- in_port to cap latency, with in_port changing before edge k:
  - DEBOUNCE = 0: s1 at k, s2 at k+1, cap set at k+2, irq high after k+2.
  - DEBOUNCE = N: f updates at k+1+N and cap is set at k+2+N.
- Reset asserted mid-debounce discards the count. Reset asserted while irq is high drops irq on the next edge.
- Counter width is 16 bits. DEBOUNCE-1 is compared at full width, with no wrap for legal values.

## Test plan
- Reset: assert reset for 2 cycles with OUT_RESET = 8'hA5 → out_port = A5, port_dir = 0, readdata = 0, irq = 0. Then read address 3 → 0.
- Rising capture (WIDTH = 8, DEBOUNCE = 0, EDGE_TYPE = 0):
  - Set mask = 8'h01, then drive in_port[0] 0→1 → cap = 01 and irq high 2 cycles later.
  - Drive 1→0 → no new capture.
  - Write 01 to address 3 → irq low next cycle.
- Debounce (DEBOUNCE = 4):
  - Pulse in_port[3] high for 3 cycles → data read 0, no capture.
  - Hold high for 4+ cycles → f[3] = 1 after 4 stable cycles, cap[3] set one cycle later.
- Set versus clear collision: in the same cycle that an edge event on bit 2 occurs, write 8'h04 to address 3 → cap[2] remains 1.
- Direction readback: write port_dir = F0, out_port = 3C, with in_port = 0F held → data read returns 8'h3F.
- Edge modes: with EDGE_TYPE = 2, toggle bit 7 twice with a clear between → two captures. With EDGE_TYPE = 1, only the 1→0 transition captures.
